// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered read ports and write-first bypass.
// After reset, a clear sequencer writes INIT_VAL to every entry while Busy is high.
module regfile_2r1w #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CS,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WAddr,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              RD0,
  input  logic              RD1,
  input  logic [ADDR_W-1:0] RAddr0,
  input  logic [ADDR_W-1:0] RAddr1,
  output logic [DATA_W-1:0] dataOut0,
  output logic [DATA_W-1:0] dataOut1,
  output logic              valid0,
  output logic              valid1,
  output logic              Busy
);

  typedef enum logic {S_CLEAR, S_READY} state_e;

  // One extra bit so DEPTH == 2**ADDR_W is representable in the range check.
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   dout0_q, dout0_d, dout1_q, dout1_d;
  logic                vld0_q, vld0_d, vld1_q, vld1_d;

  logic                ready;
  logic                wr_hit;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              hit,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd
  );
    if (!in_range(ra))        return '0;
    if (hit && (wa == ra))    return wd;
    return stored;
  endfunction

  assign ready  = (state_q == S_READY);
  assign wr_hit = ready && CS && WE && in_range(WAddr);

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      dout0_q <= '0;
      dout1_q <= '0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
    end
  end

  // Next-state logic: the clear walk ends on the edge that writes the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = S_READY;
        cnt_d   = '0;
      end
    end
  end

  // Output logic
  always_comb begin
    Busy = (state_q == S_CLEAR);
  end

  // Single memory write port shared by reset, clear sequencer and user writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = WAddr;
    mem_wd = dataIn;
    if (Rst) begin
      mem_we = 1'b1;
      mem_wa = '0;
      mem_wd = INIT_VAL;
    end else if (!ready) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = INIT_VAL;
    end else if (wr_hit) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  always_comb begin
    vld0_d  = 1'b0;
    vld1_d  = 1'b0;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    if (ready && CS && RD0) begin
      vld0_d  = 1'b1;
      dout0_d = read_sel(RAddr0, mem_q[RAddr0], wr_hit, WAddr, dataIn);
    end
    if (ready && CS && RD1) begin
      vld1_d  = 1'b1;
      dout1_d = read_sel(RAddr1, mem_q[RAddr1], wr_hit, WAddr, dataIn);
    end
  end

  assign dataOut0 = dout0_q;
  assign dataOut1 = dout1_q;
  assign valid0   = vld0_q;
  assign valid1   = vld1_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a full-depth instance (16 of 16) and a partial-depth one
// (12 of 16) share stimulus; both are tracked by an array-based reference model.
module tb_regfile_2r1w;

  localparam logic [7:0] IV = 8'hA5;

  logic             Clk = 1'b0;
  logic             Rst, CS, WE, RD0, RD1;
  logic [3:0]       WAddr, RAddr0, RAddr1;
  logic [7:0]       dataIn;
  logic [1:0]       busy, v0, v1;
  logic [1:0][7:0]  do0, do1;

  always #5 Clk = ~Clk;

  regfile_2r1w #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .INIT_VAL(IV)) u_a (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .WAddr(WAddr), .dataIn(dataIn),
    .RD0(RD0), .RD1(RD1), .RAddr0(RAddr0), .RAddr1(RAddr1),
    .dataOut0(do0[0]), .dataOut1(do1[0]), .valid0(v0[0]), .valid1(v1[0]), .Busy(busy[0])
  );

  regfile_2r1w #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .INIT_VAL(IV)) u_b (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .WAddr(WAddr), .dataIn(dataIn),
    .RD0(RD0), .RD1(RD1), .RAddr0(RAddr0), .RAddr1(RAddr1),
    .dataOut0(do0[1]), .dataOut1(do1[1]), .valid0(v0[1]), .valid1(v1[1]), .Busy(busy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: contents, remaining clear cycles and expected outputs per instance.
  int         dep [2] = '{16, 12};
  int         rem [2];
  logic [7:0] mm  [2][16];
  logic [7:0] ed0 [2];
  logic [7:0] ed1 [2];
  logic       ev0 [2];
  logic       ev1 [2];
  bit         started = 1'b0;
  string      nm  [2] = '{"a", "b"};

  task automatic chk1(input string n, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, want %b", n, act, exp);
    end
  endtask

  task automatic chk8(input string n, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, want %02h", n, act, exp);
    end
  endtask

  task automatic chk_int(input string n, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", n, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (Rst) begin
        rem[k] = dep[k];
        for (int j = 0; j < 16; j++) mm[k][j] = IV;
        ed0[k] = 8'h00; ed1[k] = 8'h00;
        ev0[k] = 1'b0;  ev1[k] = 1'b0;
      end else if (rem[k] > 0) begin
        rem[k]--;
        ev0[k] = 1'b0; ev1[k] = 1'b0;
      end else begin
        // Applying the write first gives write-first read semantics.
        if (CS && WE && int'(WAddr) < dep[k]) mm[k][WAddr] = dataIn;
        ev0[k] = CS && RD0;
        if (ev0[k]) ed0[k] = (int'(RAddr0) < dep[k]) ? mm[k][RAddr0] : 8'h00;
        ev1[k] = CS && RD1;
        if (ev1[k]) ed1[k] = (int'(RAddr1) < dep[k]) ? mm[k][RAddr1] : 8'h00;
      end
    end
    if (Rst) started = 1'b1;
  endtask

  task automatic check_model();
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk1({nm[k], ".busy"},   busy[k], rem[k] > 0);
        chk1({nm[k], ".valid0"}, v0[k],   ev0[k]);
        chk1({nm[k], ".valid1"}, v1[k],   ev1[k]);
        chk8({nm[k], ".dout0"},  do0[k],  ed0[k]);
        chk8({nm[k], ".dout1"},  do1[k],  ed1[k]);
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit w, input logic [3:0] wa,
                      input logic [7:0] d, input bit r0, input logic [3:0] a0,
                      input bit r1, input logic [3:0] a1);
    @(negedge Clk);
    Rst = r; CS = c; WE = w; WAddr = wa; dataIn = d;
    RD0 = r0; RAddr0 = a0; RD1 = r1; RAddr1 = a1;
    @(posedge Clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
    step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, a0, 1'b1, a1);
  endtask

  typedef struct {
    bit cs; bit we; logic [3:0] wa; logic [7:0] din;
    bit rd0; logic [3:0] a0; bit rd1; logic [3:0] a1;
    bit ev0; logic [7:0] ed0; bit ev1; logic [7:0] ed1;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] wv[5] = '{8'h00, 8'h01, 8'h10, 8'h06, 8'h12};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fa, fb;
    Rst = 1'b1; CS = 1'b0; WE = 1'b0; WAddr = '0; dataIn = '0;
    RD0 = 1'b0; RD1 = 1'b0; RAddr0 = '0; RAddr1 = '0;

    // Reset held for two cycles, then count edges until Busy falls on each instance.
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 4'd0, 8'hFF, 1'b1, 4'd0, 1'b1, 4'd0);
    chk1("rst.busy", busy[0], 1'b1);
    chk1("rst.valid0", v0[0], 1'b0);
    chk8("rst.dout0", do0[0], 8'h00);
    fa = 0; fb = 0;
    for (int n = 1; n <= 40; n++) begin
      step(1'b0, n <= 10, n <= 10, 4'd0, 8'hFF, 1'b1, 4'd0, 1'b1, 4'd5);
      if (busy[0] == 1'b0 && fa == 0) fa = n;
      if (busy[1] == 1'b0 && fb == 0) fb = n;
      if (fa != 0 && fb != 0) break;
    end
    chk_int("clear_len_a", fa, 16);
    chk_int("clear_len_b", fb, 12);

    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      chk1("clear.valid0", v0[0], 1'b1);
      chk8("clear.dout0", do0[0], IV);
      chk8("clear.dout1", do1[0], IV);
    end

    for (int i = 0; i < 5; i++)
      tbl.push_back('{1, 1, 4'(i), wv[i], 0, 4'd0, 0, 4'd0, 0, 8'h00, 0, 8'h00});
    for (int i = 0; i < 5; i++)
      tbl.push_back('{1, 0, 4'd0, 8'h00, 1, 4'(i), 1, 4'(4 - i), 1, wv[i], 1, wv[4 - i]});
    tbl.push_back('{1, 1, 4'd3, 8'h77, 1, 4'd3, 1, 4'd3, 1, 8'h77, 1, 8'h77});
    tbl.push_back('{1, 0, 4'd0, 8'h00, 1, 4'd3, 1, 4'd3, 1, 8'h77, 1, 8'h77});
    tbl.push_back('{0, 1, 4'd2, 8'hFF, 1, 4'd2, 1, 4'd2, 0, 8'h00, 0, 8'h00});
    tbl.push_back('{1, 0, 4'd0, 8'h00, 1, 4'd2, 0, 4'd0, 1, 8'h10, 0, 8'h00});
    tbl.push_back('{1, 1, 4'd4, 8'h99, 1, 4'd4, 1, 4'd2, 1, 8'h99, 1, 8'h10});
    tbl.push_back('{1, 0, 4'd0, 8'h00, 1, 4'd4, 0, 4'd0, 1, 8'h99, 0, 8'h00});
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].cs, tbl[i].we, tbl[i].wa, tbl[i].din,
           tbl[i].rd0, tbl[i].a0, tbl[i].rd1, tbl[i].a1);
      chk1($sformatf("vec%0d.valid0", i), v0[0], tbl[i].ev0);
      chk1($sformatf("vec%0d.valid1", i), v1[0], tbl[i].ev1);
      if (tbl[i].ev0) chk8($sformatf("vec%0d.dout0", i), do0[0], tbl[i].ed0);
      if (tbl[i].ev1) chk8($sformatf("vec%0d.dout1", i), do1[0], tbl[i].ed1);
    end

    // Address 13 lies beyond u_b's 12 entries but inside u_a.
    step(1'b0, 1'b1, 1'b1, 4'd13, 8'hEE, 1'b0, 4'd0, 1'b0, 4'd0);
    rd(4'd13, 4'd13);
    chk1("oor.b.valid0", v0[1], 1'b1);
    chk8("oor.b.dout0", do0[1], 8'h00);
    chk8("oor.a.dout0", do0[0], 8'hEE);
    for (int i = 0; i < 12; i++) rd(4'(i), 4'(11 - i));

    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 2) != 0,
           4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
    for (int n = 0; n < 40 && busy != 2'b00; n++) idle();
    chk1("rand.ready", busy[0] | busy[1], 1'b0);

    // Reset asserted during a read aborts it and restarts the clear walk.
    step(1'b0, 1'b1, 1'b1, 4'd1, 8'h55, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd1, 1'b1, 4'd1);
    chk1("midrst.busy", busy[0], 1'b1);
    chk1("midrst.valid0", v0[0], 1'b0);
    chk8("midrst.dout0", do0[0], 8'h00);
    for (int n = 0; n < 40 && busy != 2'b00; n++) idle();
    chk1("midrst.ready", busy[0] | busy[1], 1'b0);
    rd(4'd1, 4'd1);
    chk8("midrst.a.dout0", do0[0], IV);
    chk8("midrst.b.dout1", do1[1], IV);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
